prbs15_checker: RTL and testbench

- Receive-side counterpart of the prbs15 generator: consumes a serial bit stream qualified by a valid strobe and self-synchronizes to the PRBS15 sequence (x^15 + x^14 + 1).
- Once locked, predicts every bit, flags and counts bit errors, and drops lock on sustained error bursts.
- Sits after the demapper / loopback path of the OFDM baseband for BER measurement.

---
 rtl/prbs15_checker.sv | 144 ++++++++++++++
 tb/tb_prbs15_checker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs15_checker.sv
// prbs15_checker: self-synchronizing PRBS15 (x^15 + x^14 + 1) receive checker.
// Searches for the sequence, then free-runs a local predictor and counts
// bit errors; sustained error bursts drop lock and restart the search.
module prbs15_checker #(
  parameter int LOCK_CNT = 16,
  parameter int WIN_LEN  = 64,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32
) (
  input  logic             prbs_clk,
  input  logic             prbs_rst,
  input  logic             clr_cnt,
  input  logic             din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W   = $clog2(WIN_LEN + 1);
  localparam int WERR_W  = $clog2(LOSS_THR + 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [14:0]        s_reg, s_next;
  logic [3:0]         fill_reg, fill_next;
  logic [MATCH_W-1:0] match_reg, match_next, match_inc;
  logic [WIN_W-1:0]   win_reg, win_next, win_inc;
  logic [WERR_W-1:0]  werr_reg, werr_next, werr_inc;
  logic               err_pulse_reg, err_pulse_next;
  logic               pred;
  logic               mismatch;
  logic [14:0]        s_shift_din;
  logic [1:0]         cnt_inc;          // [0] bit counter, [1] error counter
  logic [1:0][CNT_W-1:0] cnt_val;

  // Predicted next bit from the 15-bit history; s[0] is the newest bit
  assign pred        = s_reg[14] ^ s_reg[13];
  assign mismatch    = din ^ pred;
  assign s_shift_din = {s_reg[13:0], din};
  // Match run saturates at the lock threshold so a long all-zero run cannot wrap
  assign match_inc   = (match_reg == MATCH_W'(LOCK_CNT)) ? match_reg : match_reg + MATCH_W'(1);
  assign win_inc     = win_reg + WIN_W'(1);
  assign werr_inc    = werr_reg + WERR_W'(mismatch);

  // State register and all per-bit tracking registers
  always_ff @(posedge prbs_clk or posedge prbs_rst) begin
    if (prbs_rst) begin
      state_reg     <= SEARCH;
      s_reg         <= '0;
      fill_reg      <= '0;
      match_reg     <= '0;
      win_reg       <= '0;
      werr_reg      <= '0;
      err_pulse_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      s_reg         <= s_next;
      fill_reg      <= fill_next;
      match_reg     <= match_next;
      win_reg       <= win_next;
      werr_reg      <= werr_next;
      err_pulse_reg <= err_pulse_next;
    end
  end

  // Next-state logic: search/lock decisions, prediction, error windowing
  always_comb begin
    state_next     = state_reg;
    s_next         = s_reg;
    fill_next      = fill_reg;
    match_next     = match_reg;
    win_next       = win_reg;
    werr_next      = werr_reg;
    err_pulse_next = 1'b0;
    cnt_inc        = 2'b00;
    if (din_valid) begin
      if (state_reg == SEARCH) begin
        // Load the received bit; compare only once 15 bits of history exist
        s_next = s_shift_din;
        if (fill_reg != 4'd15) begin
          fill_next = fill_reg + 4'd1;
        end else if (!mismatch) begin
          match_next = match_inc;
          // A zero register would lock onto a dead line, so require s != 0
          if ((match_inc == MATCH_W'(LOCK_CNT)) && (s_shift_din != 15'd0)) begin
            state_next = LOCKED;
            win_next   = '0;
            werr_next  = '0;
          end
        end else begin
          match_next = '0;
        end
      end else begin
        // Free-run on the prediction; din is only compared, never loaded
        s_next         = {s_reg[13:0], pred};
        err_pulse_next = mismatch;
        cnt_inc        = {mismatch, 1'b1};
        if (werr_inc >= WERR_W'(LOSS_THR)) begin
          // Too many errors in this window: restart the search from scratch
          state_next = SEARCH;
          s_next     = '0;
          fill_next  = '0;
          match_next = '0;
          win_next   = '0;
          werr_next  = '0;
        end else if (win_inc == WIN_W'(WIN_LEN)) begin
          win_next  = '0;
          werr_next = '0;
        end else begin
          win_next  = win_inc;
          werr_next = werr_inc;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      // Saturating counter; a clear beats an increment in the same cycle
      always_ff @(posedge prbs_clk or posedge prbs_rst) begin
        if (prbs_rst) begin
          cnt_reg <= '0;
        end else if (clr_cnt) begin
          cnt_reg <= '0;
        end else if (cnt_inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
      assign cnt_val[gi] = cnt_reg;
    end
  endgenerate

  assign locked    = (state_reg == LOCKED);
  assign err_pulse = err_pulse_reg;
  assign bit_count = cnt_val[0];
  assign err_count = cnt_val[1];

endmodule

// File: tb/tb_prbs15_checker.sv
// tb_prbs15_checker: table-driven and randomized checks of prbs15_checker
// against a sequence-level reference model.
module tb_prbs15_checker;

  localparam int LOCK_CNT = 16;
  localparam int WIN_LEN  = 64;
  localparam int LOSS_THR = 8;
  localparam int CNT_W    = 32;

  logic             prbs_clk = 1'b0;
  logic             prbs_rst = 1'b1;
  logic             clr_cnt  = 1'b0;
  logic             din      = 1'b0;
  logic             din_valid = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  prbs15_checker #(
    .LOCK_CNT(LOCK_CNT), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)
  ) dut (
    .prbs_clk (prbs_clk),
    .prbs_rst (prbs_rst),
    .clr_cnt  (clr_cnt),
    .din      (din),
    .din_valid(din_valid),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  always #5 prbs_clk = ~prbs_clk;

  int checks = 0;
  int errors = 0;
  int pulse_seen = 0;
  logic [14:0] gen_s = '1;

  // Reference model: sequence history plus a queue of error flags per window
  bit     m_locked;
  bit     m_pulse;
  longint m_err;
  longint m_bits;
  bit     hist[$];
  bit     wq[$];

  typedef struct {
    string name;
    int    n_inv;
    int    groups;
    int    spacing;
    bit    exp_locked;
    int    exp_err;
    int    exp_pulses;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit gen_next();
    bit n;
    n = gen_s[14] ^ gen_s[13];
    gen_s = {gen_s[13:0], n};
    return n;
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_pulse = 0; m_err = 0; m_bits = 0;
    hist.delete(); wq.delete();
  endfunction

  function automatic void model_step(input bit d, input bit v, input bit c);
    int n, run, sum;
    bit nz, p, e, newp;
    newp = 0;
    if (v) begin
      if (!m_locked) begin
        hist.push_back(d);
        n = hist.size();
        run = 0;
        // Length of the run of recent bits obeying b[k] = b[k-15] ^ b[k-14]
        for (int k = n - 1; k >= 15; k--) begin
          if (run >= LOCK_CNT) break;
          if (hist[k] == (hist[k-15] ^ hist[k-14])) run++;
          else break;
        end
        nz = 0;
        for (int j = (n > 15 ? n - 15 : 0); j < n; j++) nz |= hist[j];
        if (run >= LOCK_CNT && nz) begin
          m_locked = 1;
          wq.delete();
        end
      end else begin
        n = hist.size();
        p = hist[n-15] ^ hist[n-14];
        hist.push_back(p);
        e = (d != p);
        newp = e;
        if (!c) begin
          m_bits++;
          if (e) m_err++;
        end
        wq.push_back(e);
        sum = 0;
        foreach (wq[i]) sum += int'(wq[i]);
        if (sum >= LOSS_THR) begin
          m_locked = 0;
          hist.delete();
          wq.delete();
        end else if (wq.size() == WIN_LEN) begin
          wq.delete();
        end
      end
    end
    if (c) begin
      m_bits = 0;
      m_err = 0;
    end
    m_pulse = newp;
  endfunction

  // One clock: drive at negedge, model at posedge, compare at next negedge
  task automatic cycle(input bit d, input bit v, input bit c);
    din = d; din_valid = v; clr_cnt = c;
    @(posedge prbs_clk);
    model_step(d, v, c);
    @(negedge prbs_clk);
    if (err_pulse === 1'b1) pulse_seen++;
    check("cyc_locked",    longint'(locked),    longint'(m_locked));
    check("cyc_err_pulse", longint'(err_pulse), longint'(m_pulse));
    check("cyc_err_count", longint'(err_count), m_err);
    check("cyc_bit_count", longint'(bit_count), m_bits);
  endtask

  task automatic send(input int nb, input bit inv);
    repeat (nb) cycle(gen_next() ^ inv, 1'b1, 1'b0);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge
  task automatic do_reset(input string tag);
    #1 prbs_rst = 1'b1;
    #1;
    check({tag, "_locked"},    longint'(locked),    0);
    check({tag, "_err_pulse"}, longint'(err_pulse), 0);
    check({tag, "_err_count"}, longint'(err_count), 0);
    check({tag, "_bit_count"}, longint'(bit_count), 0);
    $display("reset %s: outputs locked=%0b err_pulse=%0b err_count=%0d bit_count=%0d",
             tag, locked, err_pulse, err_count, bit_count);
    model_reset();
    gen_s = '1;
    @(negedge prbs_clk);
    prbs_rst = 1'b0;
  endtask

  initial begin
    int vcnt;
    int rates[6];
    bit v, c, inv, d;

    vecs[0] = '{"isolated3", 1, 3, 25, 1'b1, 3, 3};
    vecs[1] = '{"burst7",    7, 1, 0,  1'b1, 7, 7};
    vecs[2] = '{"burst8",    8, 1, 0,  1'b0, 8, 8};
    vecs[3] = '{"isolated5", 1, 5, 21, 1'b1, 5, 5};
    rates = '{0, 32, 8, 0, 4, 64};

    model_reset();
    @(negedge prbs_clk);
    check("init_locked",    longint'(locked),    0);
    check("init_err_pulse", longint'(err_pulse), 0);
    check("init_err_count", longint'(err_count), 0);
    check("init_bit_count", longint'(bit_count), 0);
    prbs_rst = 1'b0;

    // Clean stream from seed 7FFF: lock on exactly the 31st valid bit
    send(30, 1'b0);
    check("no_lock_at_30", longint'(locked), 0);
    send(1, 1'b0);
    check("lock_at_31", longint'(locked), 1);
    send(1000, 1'b0);
    check("clean_err_count", longint'(err_count), 0);
    check("clean_bit_count", longint'(bit_count), 1000);
    $display("clean: locked=%0b err_count=%0d bit_count=%0d", locked, err_count, bit_count);

    // Error-injection vectors
    for (int i = 0; i < 4; i++) begin
      cycle(gen_next(), 1'b1, 1'b1);
      check("clr_with_bit_err", longint'(err_count), 0);
      check("clr_with_bit_bits", longint'(bit_count), 0);
      for (int w = 0; w < WIN_LEN && wq.size() != 0; w++) send(1, 1'b0);
      pulse_seen = 0;
      for (int g = 0; g < vecs[i].groups; g++) begin
        send(vecs[i].n_inv, 1'b1);
        if (g < vecs[i].groups - 1) send(vecs[i].spacing, 1'b0);
      end
      check({vecs[i].name, "_locked"}, longint'(locked), longint'(vecs[i].exp_locked));
      check({vecs[i].name, "_err"},    longint'(err_count), longint'(vecs[i].exp_err));
      check({vecs[i].name, "_pulses"}, longint'(pulse_seen), longint'(vecs[i].exp_pulses));
      $display("vector %s: locked=%0b err_count=%0d pulses=%0d",
               vecs[i].name, locked, err_count, pulse_seen);
      if (!vecs[i].exp_locked) begin
        send(30, 1'b0);
        check({vecs[i].name, "_no_relock_30"}, longint'(locked), 0);
        send(1, 1'b0);
        check({vecs[i].name, "_relock_31"}, longint'(locked), 1);
        check({vecs[i].name, "_err_held"}, longint'(err_count), longint'(vecs[i].exp_err));
        $display("vector %s relock: locked=%0b err_count=%0d", vecs[i].name, locked, err_count);
      end
    end

    // Clear while locked with five errors counted
    cycle(gen_next(), 1'b1, 1'b1);
    check("clr_locked", longint'(locked), 1);
    check("clr_err",    longint'(err_count), 0);
    check("clr_bits",   longint'(bit_count), 0);
    $display("clr: locked=%0b err_count=%0d bit_count=%0d", locked, err_count, bit_count);

    // Asynchronous reset mid-stream, then an all-zero line
    do_reset("async_rst");
    repeat (200) cycle(1'b0, 1'b1, 1'b0);
    check("zero_stream_nolock", longint'(locked), 0);
    $display("zero stream: locked=%0b bit_count=%0d", locked, bit_count);

    // 50% valid duty: lock counted in valid bits only
    do_reset("rst_half");
    vcnt = 0;
    while (!locked && vcnt < 100) begin
      cycle(gen_next(), 1'b1, 1'b0);
      vcnt++;
      cycle(($urandom_range(0, 1) == 1), 1'b0, 1'b0);
    end
    check("half_duty_lock_bits", longint'(vcnt), 31);
    repeat (100) begin
      cycle(gen_next(), 1'b1, 1'b0);
      cycle(($urandom_range(0, 1) == 1), 1'b0, 1'b0);
    end
    check("half_duty_bit_count", longint'(bit_count), 100);
    $display("half duty: lock after %0d valid bits, bit_count=%0d", vcnt, bit_count);

    // Randomized phases with varying error rates, gaps and clears
    do_reset("rst_rand");
    for (int ph = 0; ph < 6; ph++) begin
      for (int k = 0; k < 600; k++) begin
        v   = ($urandom_range(0, 3) != 0);
        c   = ($urandom_range(0, 199) == 0);
        inv = (rates[ph] != 0) && ($urandom_range(0, rates[ph] - 1) == 0);
        d   = v ? (gen_next() ^ inv) : ($urandom_range(0, 1) == 1);
        cycle(d, v, c);
      end
      $display("random phase %0d: locked=%0b err_count=%0d bit_count=%0d",
               ph, locked, err_count, bit_count);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
